// File: rtl/norm2_loader_if.sv
// norm2_loader_if
//   Groups the two streaming handshakes of the norm2 loader.
//   in_*  : sample stream into the loader. A sample moves in any cycle
//           where in_valid & in_ready are both high at the rising edge.
//   res_* : result stream out of the loader. A result moves in any cycle
//           where res_valid & res_ready are both high at the rising edge.
//           Once res_valid rises, it and res_data/res_err stay unchanged
//           until that handshake happens.
//   Modports: slave  = the loader (sample sink, result source)
//             master = the environment (sample source, result sink)
interface norm2_loader_if #(
   parameter int DATA_W = 27
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              res_valid;
   logic              res_ready;
   logic [63:0]       res_data;
   logic              res_err;

   modport slave (
      input  in_valid, in_data, res_ready,
      output in_ready, res_valid, res_data, res_err
   );

   modport master (
      output in_valid, in_data, res_ready,
      input  in_ready, res_valid, res_data, res_err
   );
endinterface

// File: rtl/norm2_loader.sv
// norm2_loader
//   Upstream sequencer for the norm2 sum-of-squares datapath. It collects N
//   samples from a stream and writes them into main's array. It then pulses
//   r_enable, waits for main's w_enable and captures result. Finally it
//   offers the result on a stream and rearms for the next batch.
//
//   Optional feature: define NORM2_LOADER_TIMEOUT_EN to abort a run after
//   TIMEOUT cycles. The abort reports res_data=0 with res_err=1. Without the
//   macro, res_err is tied to 0 and RUN waits for w_enable indefinitely.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   bus (slave)          in_valid/in_ready/in_data sample stream,
//                        res_valid/res_ready/res_data/res_err result stream
//   controlArr           1 while the loader owns main's array port
//   controlArrWEnable_a  registered array write enable
//   controlArrAddr_a     registered array write address
//   controlArrWData_a    registered array write data
//   controlArrRData_a    array read data (unused)
//   r_enable             one-cycle start pulse to main
//   init_i, init_acc     constant 0 initial values for main
//   w_enable, result     main's done strobe and sum of squares
//   dbg_state_o          current FSM state, for observation only
module norm2_loader #(
   parameter int N       = 1000,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 27,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   norm2_loader_if.slave     bus,
   output logic              controlArr,
   output logic              controlArrWEnable_a,
   output logic [ADDR_W-1:0] controlArrAddr_a,
   output logic [DATA_W-1:0] controlArrWData_a,
   input  logic [DATA_W-1:0] controlArrRData_a,
   output logic              r_enable,
   output logic [63:0]       init_i,
   output logic [63:0]       init_acc,
   input  logic              w_enable,
   input  logic [63:0]       result,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      S_LOAD    = 3'd0,
      S_LAST_WR = 3'd1,
      S_START   = 3'd2,
      S_RUN     = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // One extra bit so that N = 2**ADDR_W can be reached without wrapping.
   localparam logic [ADDR_W:0] N_C = (ADDR_W+1)'(N);

   state_t              state_q;
   logic [ADDR_W:0]     count_q;
   logic [ADDR_W:0]     count_d;
   logic                in_ready_q;
   logic                ctrl_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                ren_q;
   logic                res_valid_q;
   logic [63:0]         res_data_q;
   logic                accept;

`ifdef NORM2_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   // Counts cycles since the r_enable cycle. In the n-th RUN cycle it holds
   // n, so the abort makes res_valid rise exactly TIMEOUT cycles after
   // r_enable.
   logic [TW-1:0]       tcnt_q;
   logic                res_err_q;
`endif

   assign accept  = bus.in_valid & in_ready_q;
   assign count_d = count_q + (ADDR_W+1)'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_LOAD;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         ctrl_q      <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         ren_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
`ifdef NORM2_LOADER_TIMEOUT_EN
         tcnt_q      <= '0;
         res_err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_LOAD: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  we_q    <= 1'b1;
                  addr_q  <= count_q[ADDR_W-1:0];
                  data_q  <= bus.in_data;
                  count_q <= count_d;
                  if (count_d == N_C) begin
                     in_ready_q <= 1'b0;
                     state_q    <= S_LAST_WR;
                  end
               end else begin
                  // Address and data hold; only the strobe drops.
                  we_q <= 1'b0;
               end
            end
            S_LAST_WR: begin
               // The final write is on the array port during this cycle.
               we_q    <= 1'b0;
               ctrl_q  <= 1'b0;
               ren_q   <= 1'b1;
               state_q <= S_START;
`ifdef NORM2_LOADER_TIMEOUT_EN
               tcnt_q  <= '0;
`endif
            end
            S_START: begin
               ren_q   <= 1'b0;
               state_q <= S_RUN;
`ifdef NORM2_LOADER_TIMEOUT_EN
               tcnt_q  <= tcnt_q + TW'(1);
`endif
            end
            S_RUN: begin
               if (w_enable) begin
                  res_data_q  <= result;
                  res_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
`ifdef NORM2_LOADER_TIMEOUT_EN
               else if (tcnt_q >= TLAST) begin
                  res_data_q  <= '0;
                  res_err_q   <= 1'b1;
                  res_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  tcnt_q <= tcnt_q + TW'(1);
               end
`endif
            end
            S_DONE: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  count_q     <= '0;
                  ctrl_q      <= 1'b1;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_LOAD;
`ifdef NORM2_LOADER_TIMEOUT_EN
                  res_err_q   <= 1'b0;
`endif
               end
            end
            default: begin
               state_q <= S_LOAD;
            end
         endcase
      end
   end

   assign bus.in_ready        = in_ready_q;
   assign bus.res_valid       = res_valid_q;
   assign bus.res_data        = res_data_q;
`ifdef NORM2_LOADER_TIMEOUT_EN
   assign bus.res_err         = res_err_q;
`else
   assign bus.res_err         = 1'b0;
`endif
   assign controlArr          = ctrl_q;
   assign controlArrWEnable_a = we_q;
   assign controlArrAddr_a    = addr_q;
   assign controlArrWData_a   = data_q;
   assign r_enable            = ren_q;
   assign init_i              = '0;
   assign init_acc            = '0;
   assign dbg_state_o         = state_q;

   // Read data is never consumed, and TIMEOUT only matters with the macro.
   logic unused_ok;
   assign unused_ok = ^{controlArrRData_a, TIMEOUT[0]};

endmodule

// File: tb/tb_norm2_loader.sv
module tb_norm2_loader;
   localparam int N       = 4;
   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 27;
   localparam int TIMEOUT = 8;
   localparam logic [63:0] BAD = 64'hDEAD_BEEF_DEAD_BEEF;

   logic              clk;
   logic              rst_n;
   logic              controlArr;
   logic              controlArrWEnable_a;
   logic [ADDR_W-1:0] controlArrAddr_a;
   logic [DATA_W-1:0] controlArrWData_a;
   logic [DATA_W-1:0] controlArrRData_a;
   logic              r_enable;
   logic [63:0]       init_i;
   logic [63:0]       init_acc;
   logic              w_enable;
   logic [63:0]       result;
   logic [2:0]        dbg_state;

   norm2_loader_if #(.DATA_W(DATA_W)) bus ();

   norm2_loader #(
      .N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave),
      .controlArr(controlArr),
      .controlArrWEnable_a(controlArrWEnable_a),
      .controlArrAddr_a(controlArrAddr_a),
      .controlArrWData_a(controlArrWData_a),
      .controlArrRData_a(controlArrRData_a),
      .r_enable(r_enable),
      .init_i(init_i),
      .init_acc(init_acc),
      .w_enable(w_enable),
      .result(result),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int n_chk  = 0;
   int n_pass = 0;
   logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];   // {addr, data}
   logic [64:0]              exp_res_q[$];  // {err, data}

   int   cyc      = 0;
   int   last_acc = -100;
   int   ren_cyc  = -100;
   int   wen_cyc  = -100;
   int   ren_cnt  = 0;
   logic prev_acc = 1'b0;
   logic res_prev = 1'b0;
   logic [63:0] held_data = '0;

   logic signed [DATA_W-1:0] mem [16];
   logic stub_en       = 1'b1;
   int   spur_req_n    = 0;
   int   spur_done_n   = 0;
   int   spst_req_n    = 0;
   int   spst_done_n   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_one(input int idx, input logic signed [DATA_W-1:0] d, input int gap);
      int k;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      k = 0;
      @(negedge clk);
      while (!bus.in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!bus.in_ready) begin
         chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
         bus.in_valid = 1'b0;
      end else begin
         exp_wr_q.push_back({4'(idx), d});
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic send_batch(input logic signed [DATA_W-1:0] a, b, c, d, input int gap);
      send_one(0, a, gap);
      send_one(1, b, gap);
      send_one(2, c, gap);
      send_one(3, d, gap);
   endtask

   task automatic wait_result();
      for (int k = 0; k < 300 && exp_res_q.size() != 0; k++) @(negedge clk);
      chk("result_arrived", 64'(exp_res_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_in_ready",   64'(bus.in_ready), 64'd0);
      chk("rst_controlArr", 64'(controlArr), 64'd1);
      chk("rst_we",         64'(controlArrWEnable_a), 64'd0);
      chk("rst_addr",       64'(controlArrAddr_a), 64'd0);
      chk("rst_wdata",      64'(controlArrWData_a), 64'd0);
      chk("rst_r_enable",   64'(r_enable), 64'd0);
      chk("rst_res_valid",  64'(bus.res_valid), 64'd0);
      chk("rst_res_data",   bus.res_data, 64'd0);
      chk("rst_res_err",    64'(bus.res_err), 64'd0);
      chk("rst_init",       init_i | init_acc, 64'd0);
   endtask

   // ---------------- stub of main ----------------
   initial begin
      int     cd;
      longint s;
      longint v;
      cd       = 0;
      s        = 0;
      w_enable = 1'b0;
      result   = '0;
      forever begin
         @(posedge clk);
         #1;
         w_enable = 1'b0;
         if (!rst_n) begin
            cd = 0;
         end else begin
            if (r_enable && stub_en) begin
               s = 0;
               for (int i = 0; i < N; i++) begin
                  v = longint'(mem[i]);
                  s += v * v;
               end
               cd = 3;
            end
            if (r_enable && spst_req_n != spst_done_n) begin
               w_enable = 1'b1;
               result   = BAD;
               spst_done_n++;
            end else if (spur_req_n != spur_done_n) begin
               w_enable = 1'b1;
               result   = BAD;
               spur_done_n++;
            end else if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  w_enable = 1'b1;
                  result   = 64'(s);
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic acc;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_acc = 1'b0;
            res_prev = 1'b0;
         end else begin
            acc = bus.in_valid & bus.in_ready;
            chk("we_after_accept", 64'(controlArrWEnable_a), 64'(prev_acc));
            if (controlArrWEnable_a) begin
               if (controlArr) mem[controlArrAddr_a] = controlArrWData_a;
               if (exp_wr_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
               else chk("write_addr_data", 64'({controlArrAddr_a, controlArrWData_a}),
                        64'(exp_wr_q.pop_front()));
            end
            if (acc) last_acc = cyc;
            if (r_enable) begin
               ren_cnt++;
               ren_cyc = cyc;
               chk("r_enable_latency", 64'(cyc), 64'(last_acc + 2));
               chk("start_port_released", 64'({controlArr, controlArrWEnable_a}), 64'd0);
            end
            if (w_enable && result != BAD) wen_cyc = cyc;
            if (bus.res_valid && !res_prev) begin
               held_data = bus.res_data;
               if (exp_res_q.size() > 0 && exp_res_q[0][64])
                  chk("timeout_latency", 64'(cyc), 64'(ren_cyc + TIMEOUT));
               else
                  chk("res_valid_latency", 64'(cyc), 64'(wen_cyc + 1));
            end
            if (bus.res_valid && res_prev) begin
               chk("res_data_stable", bus.res_data, held_data);
               chk("in_ready_while_res", 64'(bus.in_ready), 64'd0);
            end
            if (bus.res_valid && bus.res_ready) begin
               if (exp_res_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
               else begin
                  logic [64:0] e;
                  e = exp_res_q.pop_front();
                  chk("res_data", bus.res_data, e[63:0]);
                  chk("res_err", 64'(bus.res_err), 64'(e[64]));
               end
            end
            res_prev = bus.res_valid;
            prev_acc = acc;
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int ren_before;
      int ren_expect;
      rst_n             = 1'b0;
      bus.in_valid      = 1'b0;
      bus.in_data       = '0;
      bus.res_ready     = 1'b1;
      controlArrRData_a = '0;
      ren_expect        = 0;

      repeat (3) @(negedge clk);
      chk_reset_outputs();
      chk("rst_state", 64'(dbg_state), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Basic batch, back-to-back samples: 1+4+9+16 = 30
      exp_res_q.push_back({1'b0, 64'd30});
      send_batch(27'sd1, 27'sd2, 27'sd3, 27'sd4, 0);
      wait_result();
      ren_expect++;

      // Gaps plus result backpressure: 25+0+49+1 = 75
      bus.res_ready = 1'b0;
      exp_res_q.push_back({1'b0, 64'd75});
      send_batch(-27'sd5, 27'sd0, 27'sd7, -27'sd1, 1);
      for (int k = 0; k < 100 && !bus.res_valid; k++) @(negedge clk);
      chk("res_valid_seen", 64'(bus.res_valid), 64'd1);
      repeat (10) @(posedge clk);
      #1;
      bus.res_ready = 1'b1;
      wait_result();
      ren_expect++;

      // Next batch with spurious w_enable in LOAD and in START: 4*4 = 16
      spst_req_n++;
      send_one(0, 27'sd2, 0);
      send_one(1, 27'sd2, 0);
      spur_req_n++;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("spurious_load_state", 64'(dbg_state), 64'd0);
      send_one(2, 27'sd2, 0);
      send_one(3, 27'sd2, 0);
      exp_res_q.push_back({1'b0, 64'd16});
      wait_result();
      chk("spurious_start_used", 64'(spst_done_n), 64'(spst_req_n));
      ren_expect++;

      // Reset after two of four samples
      ren_before = ren_cnt;
      send_one(0, 27'sd9, 0);
      send_one(1, 27'sd9, 0);
      rst_n = 1'b0;
      exp_wr_q.delete();
      @(negedge clk);
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_res_q.push_back({1'b0, 64'd4});
      send_batch(27'sd1, 27'sd1, 27'sd1, 27'sd1, 0);
      wait_result();
      ren_expect++;
      chk("ren_after_reset", 64'(ren_cnt), 64'(ren_before + 1));

`ifdef NORM2_LOADER_TIMEOUT_EN
      // main never answers: abort TIMEOUT cycles after r_enable
      stub_en = 1'b0;
      exp_res_q.push_back({1'b1, 64'd0});
      send_batch(27'sd1, 27'sd1, 27'sd1, 27'sd1, 0);
      wait_result();
      ren_expect++;
      @(negedge clk);
      chk("res_err_cleared", 64'(bus.res_err), 64'd0);
      stub_en = 1'b1;
`endif

      repeat (3) @(negedge clk);
      chk("total_r_enable", 64'(ren_cnt), 64'(ren_expect));
      chk("writes_drained", 64'(exp_wr_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/norm2_loader.md
Name: norm2_loader

Overview:
Upstream sequencer for the norm2 datapath (`main`, sum of squares over a 27-bit signed array). It accepts N samples on a valid/ready stream and writes them into main's array through the controlArr write port. It then pulses r_enable, waits for main's w_enable and captures result. The result is presented on a valid/ready output, after which the block rearms for the next batch.

Parameters:
N, 1000, samples per batch; must satisfy 1 <= N <= 2**ADDR_W
ADDR_W, 10, array address width
DATA_W, 27, sample width (signed)
TIMEOUT, 4096, max cycles in RUN before abort (used only with NORM2_LOADER_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid & in_ready
in_data  in  DATA_W  signed sample
controlArr  out  1  1 = loader owns main's array port
controlArrWEnable_a  out  1  array write enable
controlArrAddr_a  out  ADDR_W  array write address
controlArrWData_a  out  DATA_W  array write data
controlArrRData_a  in  DATA_W  unused; tie-off only
r_enable  out  1  one-cycle start pulse to main
init_i  out  64  constant 0
init_acc  out  64  constant 0
w_enable  in  1  main done strobe; result valid this cycle
result  in  64  main's sum of squares
res_valid  out  1  result available
res_ready  in  1  consumer accepts when res_valid & res_ready
res_data  out  64  captured result
res_err  out  1  timeout flag; constant 0 when the macro is off

Behaviour:
- Reset (async assert, sync release): state=LOAD, count=0.
  - Outputs: in_ready=0, controlArr=1, controlArrWEnable_a=0, controlArrAddr_a=0, controlArrWData_a=0, r_enable=0, res_valid=0, res_data=0, res_err=0.
  - Reset mid-batch discards all progress. Main is not started and no result is emitted.
- States: LOAD -> LAST_WR -> START -> RUN -> DONE -> LOAD.
- LOAD:
  - in_ready=1 from the first cycle after reset release; controlArr=1.
  - On accept: next cycle drive controlArrWEnable_a=1, controlArrAddr_a=count, controlArrWData_a=in_data (registered, 1-cycle latency); count increments.
  - In a cycle with no accept, next-cycle controlArrWEnable_a=0. Addr/data hold.
  - When the accept makes count reach N, go to LAST_WR; in_ready=0 from then on.
- LAST_WR: one cycle. controlArr=1 and the final write is visible. Go to START.
- START: one cycle. controlArr=0, controlArrWEnable_a=0, r_enable=1. Go to RUN.
- RUN:
  - controlArr=0, r_enable=0.
  - On w_enable=1: res_data<=result, res_valid<=1 next cycle, go to DONE.
- DONE:
  - res_valid held until res_ready; res_data stable while res_valid.
  - On handshake: res_valid=0 next cycle, count=0, go to LOAD with controlArr=1.
- w_enable in any state other than RUN is ignored.
- The data path is pure pass-through: no sign or width conversion. count is ADDR_W+1 bits wide so N=2**ADDR_W does not wrap.

Optional Feature:
NORM2_LOADER_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT before w_enable: go to DONE with res_data=0 and res_err=1.
  - res_err clears together with res_valid on handshake.
- Undefined: no counter is instantiated, res_err is tied to 0, and RUN waits indefinitely.

Test Plan:
- Basic batch: N=4, samples 1,2,3,4 back-to-back. Stub main returns sum of squares.
  - Writes at addr 0..3 with data 1..4.
  - Exactly one r_enable pulse, 2 cycles after the 4th accept.
  - res_valid with res_data=30, 1 cycle after w_enable.
- Gaps: N=4, samples -5,0,7,-1 with in_valid low on alternate cycles.
  - controlArrWEnable_a is high only in the cycle after each accept.
  - Wrap-encoded data matches the samples; res_data=75.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid.
  - res_valid and res_data stay constant; in_ready stays 0.
  - After the handshake, the next batch of 2,2,2,2 yields 16.
- Spurious done: pulse w_enable during LOAD and during START.
  - No state change; the final result is still correct.
- Reset mid-load: assert rst_n=0 after 2 of 4 samples.
  - All outputs return to reset values and no r_enable occurs.
  - A fresh batch of 1,1,1,1 yields 4.
- Timeout (macro on, TIMEOUT=8): stub never asserts w_enable.
  - 8 cycles after r_enable: res_valid=1, res_err=1, res_data=0.
  - After the handshake: res_err=0.
